// File: rtl/morty_clint_pkg.sv
// Shared definitions for the morty_clint timer / software-interrupt block:
// register offsets, Wishbone FSM encoding and a byte-lane merge helper.
package morty_clint_pkg;

  // Register offsets within the 32-byte window (wbs_addr_i[4:0])
  localparam logic [4:0] MSIP_OFF        = 5'h00;
  localparam logic [4:0] MTIMECMP_LO_OFF = 5'h08;
  localparam logic [4:0] MTIMECMP_HI_OFF = 5'h0C;
  localparam logic [4:0] MTIME_LO_OFF    = 5'h10;
  localparam logic [4:0] MTIME_HI_OFF    = 5'h14;

  // Wishbone slave FSM: IDLE accepts, RESP carries the single ack/err pulse
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Replace the bytes of cur selected by sel with the matching bytes of data
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/morty_clint_timer.sv
// Free-running 64-bit mtime with prescaler, half-word software load and a
// registered mtime >= mtimecmp compare that produces the timer interrupt.
module morty_clint_timer
  import morty_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_sel,
  input  logic [63:0] mtimecmp,
  output logic [63:0] mtime,
  output logic        mtip
);

  logic [15:0] prescale;
  logic        tick;

  assign tick = (prescale == 16'(TICK_DIV - 1));

  // Prescaler counts 0..TICK_DIV-1 and keeps running through mtime loads
  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || tick) prescale <= '0;
    else               prescale <= prescale + 16'd1;
  end

  // mtime: a software load of one half suppresses that cycle's increment
  always_ff @(posedge clk_i) begin
    if (rst_i)      mtime          <= '0;
    else if (wr_lo) mtime[31:0]    <= merge_bytes(mtime[31:0], wr_data, wr_sel);
    else if (wr_hi) mtime[63:32]   <= merge_bytes(mtime[63:32], wr_data, wr_sel);
    else if (tick)  mtime          <= mtime + 64'd1;
  end

  // Timer interrupt is a registered unsigned compare of the current values
  always_ff @(posedge clk_i) begin
    if (rst_i) mtip <= 1'b0;
    else       mtip <= (mtime >= mtimecmp);
  end

endmodule

// File: rtl/morty_clint.sv
// CLINT-style Wishbone classic slave: msip / mtimecmp / mtime registers with
// a two-state response FSM and the machine timer / software interrupt outputs.
module morty_clint
  import morty_clint_pkg::*;
#(
  parameter int unsigned TICK_DIV     = 1,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        xint_mtip_o,
  output logic        xint_msip_o
);

  state_t      state;
  logic [4:0]  offset;
  logic        hit;
  logic        bad;
  logic        accept;
  logic        wr_en;
  logic [31:0] rdata;
  logic [63:0] mtimecmp;
  logic [63:0] mtime;
  logic        msip;
  logic        unused_addr;

  assign offset      = wbs_addr_i[4:0];
  assign unused_addr = ^wbs_addr_i[31:5];  // upper bits belong to the interconnect

  // Offset decode: only the five implemented, word-aligned offsets are legal
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    hit = 1'b0;
    case (offset)
      MSIP_OFF, MTIMECMP_LO_OFF, MTIMECMP_HI_OFF,
      MTIME_LO_OFF, MTIME_HI_OFF: hit = 1'b1;
      default:                    hit = 1'b0;
    endcase
  end

  assign bad    = (wbs_addr_i[1:0] != 2'b00) || !hit;
  assign accept = (state == IDLE) && wbs_cyc_i && wbs_stb_i;
  assign wr_en  = accept && wbs_we_i && !bad;

  // Read mux of current register values, captured at acceptance
  always_comb begin
    rdata = '0;
    case (offset)
      MSIP_OFF:        rdata = {31'd0, msip};
      MTIMECMP_LO_OFF: rdata = mtimecmp[31:0];
      MTIMECMP_HI_OFF: rdata = mtimecmp[63:32];
      MTIME_LO_OFF:    rdata = mtime[31:0];
      MTIME_HI_OFF:    rdata = mtime[63:32];
      default:         rdata = '0;
    endcase
  end

  // Response FSM: one registered ack/err pulse per accepted access, data zero otherwise
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= RESP;
            if (bad) begin
              wbs_err_o <= 1'b1;
            end else begin
              wbs_ack_o <= 1'b1;
              if (!wbs_we_i) wbs_dat_o <= rdata;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Software-visible mtimecmp and msip registers, byte-lane writes
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mtimecmp <= MTIMECMP_RST;
      msip     <= 1'b0;
    end else if (wr_en) begin
      case (offset)
        MSIP_OFF:        if (wbs_sel_i[0]) msip <= wbs_dat_i[0];
        MTIMECMP_LO_OFF: mtimecmp[31:0]  <= merge_bytes(mtimecmp[31:0], wbs_dat_i, wbs_sel_i);
        MTIMECMP_HI_OFF: mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], wbs_dat_i, wbs_sel_i);
        default: ;
      endcase
    end
  end

  morty_clint_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wr_lo    (wr_en && (offset == MTIME_LO_OFF)),
    .wr_hi    (wr_en && (offset == MTIME_HI_OFF)),
    .wr_data  (wbs_dat_i),
    .wr_sel   (wbs_sel_i),
    .mtimecmp (mtimecmp),
    .mtime    (mtime),
    .mtip     (xint_mtip_o)
  );

  assign xint_msip_o = msip;

endmodule

// File: tb/tb_morty_clint.sv
// Self-checking bench for morty_clint: two instances (TICK_DIV=1 and 4) on a
// shared bus, checked against a cycle-level behavioural model of the register file.
module tb_morty_clint;

  localparam int unsigned TD0 = 1;
  localparam int unsigned TD1 = 4;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        cyc0, cyc1;
  logic        stb, we;
  logic [31:0] addr, wdata;
  logic [3:0]  sel;
  logic [31:0] dat_o [2];
  logic [1:0]  ack, err, mtip, msip;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  morty_clint #(.TICK_DIV(TD0)) u_dut0 (
    .clk_i(clk), .rst_i(rst0), .wbs_addr_i(addr), .wbs_dat_i(wdata), .wbs_sel_i(sel),
    .wbs_we_i(we), .wbs_cyc_i(cyc0), .wbs_stb_i(stb), .wbs_dat_o(dat_o[0]),
    .wbs_ack_o(ack[0]), .wbs_err_o(err[0]), .xint_mtip_o(mtip[0]), .xint_msip_o(msip[0])
  );

  morty_clint #(.TICK_DIV(TD1)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .wbs_addr_i(addr), .wbs_dat_i(wdata), .wbs_sel_i(sel),
    .wbs_we_i(we), .wbs_cyc_i(cyc1), .wbs_stb_i(stb), .wbs_dat_o(dat_o[1]),
    .wbs_ack_o(ack[1]), .wbs_err_o(err[1]), .xint_mtip_o(mtip[1]), .xint_msip_o(msip[1])
  );

  // ---------------- behavioural model ----------------
  logic [63:0] m_time [2];
  logic [63:0] m_cmp  [2];
  logic        m_msip [2];
  logic        m_mtip [2];
  logic [31:0] exp_rd [2];
  longint      n_cyc  [2];

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[4:0] == 5'h04) || (a[4:0] == 5'h18) || (a[4:0] == 5'h1C);
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int d, input logic [4:0] off);
    case (off)
      5'h00:   return {31'd0, m_msip[d]};
      5'h08:   return m_cmp[d][31:0];
      5'h0C:   return m_cmp[d][63:32];
      5'h10:   return m_time[d][31:0];
      5'h14:   return m_time[d][63:32];
      default: return 32'd0;
    endcase
  endfunction

  // One clock of the model: mtime advances on every TD-th cycle since reset,
  // an accepted write to an mtime half replaces that cycle's advance.
  task automatic model_step(input int d, input logic r, input logic c, input int unsigned td);
    logic       acc, tick, time_wr;
    logic [4:0] off;
    if (r) begin
      m_time[d] = 64'd0; m_cmp[d] = '1; m_msip[d] = 1'b0; m_mtip[d] = 1'b0; n_cyc[d] = 0;
      return;
    end
    off     = addr[4:0];
    acc     = c && stb && !addr_bad(addr);
    tick    = (n_cyc[d] % longint'(td)) == longint'(td - 1);
    n_cyc[d]++;
    m_mtip[d] = (m_time[d] >= m_cmp[d]);
    time_wr = acc && we && (off == 5'h10 || off == 5'h14);
    if (acc && !we) exp_rd[d] = m_read(d, off);
    if (acc && we) begin
      case (off)
        5'h00: if (sel[0]) m_msip[d] = wdata[0];
        5'h08: m_cmp[d][31:0]   = lanes(m_cmp[d][31:0], wdata, sel);
        5'h0C: m_cmp[d][63:32]  = lanes(m_cmp[d][63:32], wdata, sel);
        5'h10: m_time[d][31:0]  = lanes(m_time[d][31:0], wdata, sel);
        5'h14: m_time[d][63:32] = lanes(m_time[d][63:32], wdata, sel);
        default: ;
      endcase
    end
    if (!time_wr && tick) m_time[d] = m_time[d] + 64'd1;
  endtask

  always @(posedge clk) begin
    model_step(0, rst0, cyc0, TD0);
    model_step(1, rst1, cyc1, TD1);
  end

  // ---------------- bus access ----------------
  // Starts #1 after a posedge; the access is accepted at the next posedge.
  task automatic bus(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] s, output logic [31:0] rd);
    logic exp_e;
    exp_e = addr_bad(a);
    addr = a; wdata = wd; sel = s; we = w; stb = 1'b1;
    if (d == 0) cyc0 = 1'b1; else cyc1 = 1'b1;
    rd = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        stb = 1'b0; cyc0 = 1'b0; cyc1 = 1'b0; we = 1'b0;
        rd = dat_o[d];
        n_checks++;
        if (ack[d] !== !exp_e || err[d] !== exp_e) begin
          n_fail++;
          $display("FAIL resp dut%0d addr=%h: ack=%b err=%b, want ack=%b err=%b",
                   d, a, ack[d], err[d], !exp_e, exp_e);
        end
        if (exp_e || !w) begin
          n_checks++;
          if (dat_o[d] !== (exp_e ? 32'd0 : exp_rd[d])) begin
            n_fail++;
            $display("FAIL rdata dut%0d addr=%h: got %h, want %h", d, a, dat_o[d],
                     exp_e ? 32'd0 : exp_rd[d]);
          end
        end
      end else begin
        n_checks++;
        if (ack[d] !== 1'b0 || err[d] !== 1'b0 || dat_o[d] !== 32'd0) begin
          n_fail++;
          $display("FAIL idle_after_resp dut%0d: ack=%b err=%b dat=%h, want 0 0 0",
                   d, ack[d], err[d], dat_o[d]);
        end
      end
      n_checks++;
      if (mtip[d] !== m_mtip[d] || msip[d] !== m_msip[d]) begin
        n_fail++;
        $display("FAIL irq dut%0d: mtip=%b msip=%b, want mtip=%b msip=%b",
                 d, mtip[d], msip[d], m_mtip[d], m_msip[d]);
      end
    end
  endtask

  task automatic do_reset(input int d);
    if (d == 0) rst0 = 1'b1; else rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (d == 0) rst0 = 1'b0; else rst1 = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ack !== 2'b00 || err !== 2'b00 || mtip !== 2'b00 || msip !== 2'b00 ||
        dat_o[0] !== 32'd0 || dat_o[1] !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b err=%b mtip=%b msip=%b dat0=%h dat1=%h, want all 0",
               ack, err, mtip, msip, dat_o[0], dat_o[1]);
    end
    rst0 = 1'b0; rst1 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      bus(d, 1'b0, 32'h0C, 32'd0, 4'h0, rd);
      n_checks++;
      if (rd !== 32'hFFFF_FFFF) begin
        n_fail++; $display("FAIL reset_mtimecmp_hi dut%0d: got %h, want ffffffff", d, rd);
      end
      bus(d, 1'b0, 32'h00, 32'd0, 4'h0, rd);
      n_checks++;
      if (rd !== 32'd0) begin
        n_fail++; $display("FAIL reset_msip dut%0d: got %h, want 00000000", d, rd);
      end
    end
  endtask

  task automatic test_mtime_read();
    logic [31:0] rd;
    do_reset(0);
    repeat (10) @(posedge clk);
    #1;
    bus(0, 1'b0, 32'h10, 32'd0, 4'h0, rd);
    n_checks++;
    if (rd !== 32'd10) begin
      n_fail++; $display("FAIL mtime_after_10: got %0d, want 10", rd);
    end
  endtask

  task automatic test_timer_irq();
    logic [31:0] rd;
    int          waited;
    do_reset(0);
    bus(0, 1'b1, 32'h0C, 32'd0,  4'hF, rd);
    bus(0, 1'b1, 32'h08, 32'h20, 4'hF, rd);
    waited = 0;
    while (m_time[0] != 64'h20 && waited < 200) begin
      @(posedge clk); #1; waited++;
    end
    n_checks++;
    if (waited >= 200) begin
      n_fail++; $display("FAIL mtip_wait: timeout, mtime model=%h, want 20", m_time[0]);
    end
    n_checks++;
    if (mtip[0] !== 1'b0) begin
      n_fail++; $display("FAIL mtip_early: got %b when mtime reaches 0x20, want 0", mtip[0]);
    end
    @(posedge clk); #1;
    n_checks++;
    if (mtip[0] !== 1'b1) begin
      n_fail++; $display("FAIL mtip_rise: got %b one cycle after match, want 1", mtip[0]);
    end
    bus(0, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, rd);
    n_checks++;
    if (mtip[0] !== 1'b0) begin
      n_fail++; $display("FAIL mtip_clear: got %b after mtimecmp raised, want 0", mtip[0]);
    end
  endtask

  task automatic test_msip();
    logic [31:0] rd;
    bus(0, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'b0001, rd);
    bus(0, 1'b0, 32'h00, 32'd0, 4'h0, rd);
    n_checks++;
    if (rd !== 32'h1 || msip[0] !== 1'b1) begin
      n_fail++; $display("FAIL msip_set: rd=%h msip=%b, want 00000001 1", rd, msip[0]);
    end
    bus(0, 1'b1, 32'h00, 32'hFFFF_FFFF, 4'b1110, rd);
    n_checks++;
    if (msip[0] !== 1'b1) begin
      n_fail++; $display("FAIL msip_lane: msip=%b after write without lane 0, want 1", msip[0]);
    end
    bus(0, 1'b1, 32'h00, 32'd0, 4'hF, rd);
    n_checks++;
    if (msip[0] !== 1'b0) begin
      n_fail++; $display("FAIL msip_clear: msip=%b, want 0", msip[0]);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    bus(0, 1'b1, 32'h18, 32'h0,  4'hF, rd);
    bus(0, 1'b0, 32'h18, 32'h0,  4'hF, rd);
    bus(0, 1'b1, 32'h02, 32'h1,  4'hF, rd);
    bus(0, 1'b0, 32'h02, 32'h0,  4'hF, rd);
    bus(0, 1'b1, 32'h0A, 32'h0,  4'hF, rd);
    bus(0, 1'b1, 32'h1C, 32'h0,  4'hF, rd);
    bus(0, 1'b0, 32'h08, 32'h0,  4'h0, rd);
    n_checks++;
    if (rd !== 32'hFFFF_FFFF || msip[0] !== 1'b0) begin
      n_fail++; $display("FAIL err_no_side_effect: cmp_lo=%h msip=%b, want ffffffff 0", rd, msip[0]);
    end
  endtask

  task automatic test_prescale();
    logic [31:0] r1, r2, r3, rd;
    int          guard;
    do_reset(1);
    bus(1, 1'b0, 32'h10, 32'd0, 4'h0, r1);
    bus(1, 1'b0, 32'h10, 32'd0, 4'h0, r2);
    bus(1, 1'b0, 32'h10, 32'd0, 4'h0, r3);
    n_checks++;
    if (r3 - r1 !== 32'd1) begin
      n_fail++; $display("FAIL tick_div4: reads %0d and %0d 4 cycles apart, want difference 1", r1, r3);
    end
    // Land the write on a tick edge
    guard = 0;
    while ((n_cyc[1] % 4) != 3 && guard < 8) begin
      @(posedge clk); #1; guard++;
    end
    bus(1, 1'b1, 32'h10, 32'h100, 4'hF, rd);
    bus(1, 1'b0, 32'h10, 32'd0, 4'h0, rd);
    n_checks++;
    if (rd !== 32'h100) begin
      n_fail++; $display("FAIL load_on_tick: got %h, want 00000100", rd);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    int          guard;
    guard = 0;
    while ((n_cyc[1] % 4) != 0 && guard < 8) begin
      @(posedge clk); #1; guard++;
    end
    bus(1, 1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, rd);
    bus(1, 1'b1, 32'h14, 32'hFFFF_FFFF, 4'hF, rd);
    repeat (4) @(posedge clk);
    #1;
    bus(1, 1'b0, 32'h10, 32'd0, 4'h0, rd);
    n_checks++;
    if (rd !== 32'h1) begin
      n_fail++; $display("FAIL wrap_lo: got %h, want 00000001", rd);
    end
    bus(1, 1'b0, 32'h14, 32'd0, 4'h0, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_fail++; $display("FAIL wrap_hi: got %h, want 00000000", rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    // Reset together with the strobe: nothing accepted, nothing written
    addr = 32'h00; wdata = 32'h1; sel = 4'hF; we = 1'b1; stb = 1'b1; cyc1 = 1'b1; rst1 = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc1 = 1'b0; we = 1'b0; rst1 = 1'b0;
    n_checks++;
    if (ack[1] !== 1'b0 || err[1] !== 1'b0 || msip[1] !== 1'b0) begin
      n_fail++; $display("FAIL rst_at_accept: ack=%b err=%b msip=%b, want 0 0 0", ack[1], err[1], msip[1]);
    end
    // Reset while the response is out: no further termination follows
    addr = 32'h10; we = 1'b0; stb = 1'b1; cyc1 = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc1 = 1'b0; rst1 = 1'b1;
    @(posedge clk); #1;
    rst1 = 1'b0;
    n_checks++;
    if (ack[1] !== 1'b0 || err[1] !== 1'b0) begin
      n_fail++; $display("FAIL rst_in_resp: ack=%b err=%b, want 0 0", ack[1], err[1]);
    end
    bus(1, 1'b0, 32'h00, 32'd0, 4'h0, rd);
  endtask

  task automatic test_random();
    logic [31:0] rd, a;
    logic [4:0]  offs [8];
    offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};
    for (int i = 0; i < 60; i++) begin
      a = {$urandom_range(0, 7'h7F) << 25, 20'd0, 7'd0, offs[$urandom_range(0, 7)]};
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      bus(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom(),
          4'($urandom_range(0, 15)), rd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; cyc0 = 1'b0; cyc1 = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0;
    test_reset();
    test_mtime_read();
    test_timer_irq();
    test_msip();
    test_errors();
    test_prescale();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
